// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback/memory-write trace buffer.
// FSM encoding, entry kind codes and entry width arithmetic.
package wb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    localparam int TS_W = 16;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Packed entry layout is {kind, addr, data, pc[, ts]}.
    function automatic int entry_w(input int ra_w, input int ma_w, input int data_w,
                                   input int pc_w, input int ts_w);
        return 1 + max_w(ra_w, ma_w) + data_w + pc_w + ts_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop first-word-fall-through FIFO.
// Latency: a word pushed at edge N is visible on head_dat after edge N.
// Backpressure: none internally; the caller must never push more than the free space.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [1:0]               push_n,
    input  logic [WIDTH-1:0]         push_dat0,
    input  logic [WIDTH-1:0]         push_dat1,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;

    assign wr_ptr_nxt = wr_ptr + AW'(1);
    assign pop_ok     = pop & ~empty;
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head_dat   = mem[rd_ptr];

    // Storage carries no reset; the top masks head_dat while empty.
    always_ff @(posedge clock) begin
        if (!clear) begin
            if (push_n != 2'd0) mem[wr_ptr]     <= push_dat0;
            if (push_n == 2'd2) mem[wr_ptr_nxt] <= push_dat1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(push_n) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures register-writeback and memory-write events into a trace FIFO (optional WB_TRACE_TIMESTAMP_EN).
// Latency: an event captured at edge N is presented on trace_* after edge N (FWFT).
// Backpressure: trace_valid/trace_ready; when the buffer is full new events are dropped and overflow sticks.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int MA_W   = 8,
    parameter int PC_W   = 8,
    parameter int DEPTH  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         reg_write,
    input  logic [RA_W-1:0]              reg_write_address,
    input  logic [DATA_W-1:0]            reg_write_data,
    input  logic                         mem_write,
    input  logic [MA_W-1:0]              mem_write_address,
    input  logic [DATA_W-1:0]            mem_write_data,
    input  logic [PC_W-1:0]              now_program_counter,
    input  logic                         instr_stop,
    input  logic                         trace_ready,
    output logic                         trace_valid,
    output logic                         trace_kind,
    output logic [max_w(RA_W,MA_W)-1:0]  trace_addr,
    output logic [DATA_W-1:0]            trace_data,
    output logic [PC_W-1:0]              trace_pc,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
`ifdef WB_TRACE_TIMESTAMP_EN
    output logic [15:0]                  trace_ts,
`endif
    output logic [1:0]                   state
);
    localparam int AD_W = max_w(RA_W, MA_W);
    localparam int CW   = $clog2(DEPTH) + 1;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int EW   = entry_w(RA_W, MA_W, DATA_W, PC_W, TS_W);
`else
    localparam int EW   = entry_w(RA_W, MA_W, DATA_W, PC_W, 0);
`endif

    typedef struct packed {
        logic              kind;
        logic [AD_W-1:0]   addr;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } entry_t;

    state_t     state_q;
    logic       overflow_q;
    logic       capturing;
    logic       restart;
    logic       ev_reg;
    logic       ev_mem;
    logic [1:0] n_ev;
    logic [1:0] push_n;
    logic       drop;
    logic       pop;
    logic [CW:0] free;
    entry_t     reg_e;
    entry_t     mem_e;
    entry_t     first_e;
    entry_t     head_e;
    logic [EW-1:0] head_dat;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Loaded with 1 on the arm edge so the arm cycle itself counts as 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else if (arm && (state_q == ST_IDLE || state_q == ST_CAPTURE)) begin
            ts_q <= TS_W'(1);
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign trace_ts = head_e.ts;
`endif

    assign capturing = (state_q == ST_CAPTURE);
    // A restart discards everything, including events arriving in the arm cycle.
    assign restart   = arm && (state_q == ST_IDLE || state_q == ST_CAPTURE);
    assign ev_reg    = capturing & ~arm & reg_write;
    assign ev_mem    = capturing & ~arm & mem_write;
    assign pop       = trace_valid & trace_ready & ~restart;

    always_comb begin
        reg_e      = '0;
        reg_e.kind = KIND_REG;
        reg_e.addr = AD_W'(reg_write_address);
        reg_e.data = reg_write_data;
        reg_e.pc   = now_program_counter;
        mem_e      = '0;
        mem_e.kind = KIND_MEM;
        mem_e.addr = AD_W'(mem_write_address);
        mem_e.data = mem_write_data;
        mem_e.pc   = now_program_counter;
`ifdef WB_TRACE_TIMESTAMP_EN
        reg_e.ts   = ts_q;
        mem_e.ts   = ts_q;
`endif
        first_e    = ev_reg ? reg_e : mem_e;
    end

    // The register event sits first, so when only one slot is left the memory event is the one dropped.
    always_comb begin
        n_ev   = {1'b0, ev_reg} + {1'b0, ev_mem};
        free   = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
        push_n = n_ev;
        drop   = 1'b0;
        if ((CW+1)'(n_ev) > free) begin
            push_n = free[1:0];
            drop   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q    <= ST_CAPTURE;
                        overflow_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (arm) begin
                        overflow_q <= 1'b0;
                    end else begin
                        if (drop)       overflow_q <= 1'b1;
                        if (instr_stop) state_q    <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (empty) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (restart),
        .push_n    (push_n),
        .push_dat0 (first_e),
        .push_dat1 (mem_e),
        .pop       (pop),
        .head_dat  (head_dat),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign head_e      = empty ? '0 : entry_t'(head_dat);
    assign trace_valid = ~empty;
    assign trace_kind  = head_e.kind;
    assign trace_addr  = head_e.addr;
    assign trace_data  = head_e.data;
    assign trace_pc    = head_e.pc;
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with DEPTH=8; covers the timestamp when WB_TRACE_TIMESTAMP_EN is defined.
module tb_wb_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic        reg_write;
    logic [3:0]  reg_write_address;
    logic [15:0] reg_write_data;
    logic        mem_write;
    logic [7:0]  mem_write_address;
    logic [15:0] mem_write_data;
    logic [7:0]  now_program_counter;
    logic        instr_stop;
    logic        trace_ready;
    logic        trace_valid;
    logic        trace_kind;
    logic [7:0]  trace_addr;
    logic [15:0] trace_data;
    logic [7:0]  trace_pc;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [1:0]  state;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] trace_ts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    wb_trace_buffer #(
        .DATA_W (16),
        .RA_W   (4),
        .MA_W   (8),
        .PC_W   (8),
        .DEPTH  (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .arm                 (arm),
        .reg_write           (reg_write),
        .reg_write_address   (reg_write_address),
        .reg_write_data      (reg_write_data),
        .mem_write           (mem_write),
        .mem_write_address   (mem_write_address),
        .mem_write_data      (mem_write_data),
        .now_program_counter (now_program_counter),
        .instr_stop          (instr_stop),
        .trace_ready         (trace_ready),
        .trace_valid         (trace_valid),
        .trace_kind          (trace_kind),
        .trace_addr          (trace_addr),
        .trace_data          (trace_data),
        .trace_pc            (trace_pc),
        .count               (count),
        .full                (full),
        .empty               (empty),
        .overflow            (overflow),
`ifdef WB_TRACE_TIMESTAMP_EN
        .trace_ts            (trace_ts),
`endif
        .state               (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic r, input logic m, input logic [3:0] ra, input logic [7:0] ma,
                        input logic [15:0] rd, input logic [15:0] md, input logic [7:0] pc);
        reg_write           = r;
        mem_write           = m;
        reg_write_address   = ra;
        mem_write_address   = ma;
        reg_write_data      = rd;
        mem_write_data      = md;
        now_program_counter = pc;
        tick();
        reg_write = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic k, input logic [7:0] a,
                           input logic [15:0] d, input logic [7:0] pc);
        chk({tag, ".valid"}, 32'(trace_valid), 32'd1);
        chk({tag, ".kind"},  32'(trace_kind),  32'(k));
        chk({tag, ".addr"},  32'(trace_addr),  32'(a));
        chk({tag, ".data"},  32'(trace_data),  32'(d));
        chk({tag, ".pc"},    32'(trace_pc),    32'(pc));
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".state"},    32'(state),       32'd0);
        chk({tag, ".count"},    32'(count),       32'd0);
        chk({tag, ".empty"},    32'(empty),       32'd1);
        chk({tag, ".full"},     32'(full),        32'd0);
        chk({tag, ".overflow"}, 32'(overflow),    32'd0);
        chk({tag, ".valid"},    32'(trace_valid), 32'd0);
        chk({tag, ".kind"},     32'(trace_kind),  32'd0);
        chk({tag, ".addr"},     32'(trace_addr),  32'd0);
        chk({tag, ".data"},     32'(trace_data),  32'd0);
        chk({tag, ".pc"},       32'(trace_pc),    32'd0);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
        reg_write_address = '0; reg_write_data = '0; mem_write_address = '0;
        mem_write_data = '0; now_program_counter = '0; instr_stop = 1'b0; trace_ready = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Three writebacks held with trace_ready low, then drained in order.
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm.state", 32'(state), 32'd1);
        push(1, 0, 4'h1, 8'h00, 16'h0011, 16'h0, 8'h01);
        chk("fwft.valid", 32'(trace_valid), 32'd1);
        push(1, 0, 4'h2, 8'h00, 16'h0022, 16'h0, 8'h02);
        push(1, 0, 4'h3, 8'h00, 16'h0033, 16'h0, 8'h03);
        chk("seq.count", 32'(count), 32'd3);
        pop_chk("seq0", 1'b0, 8'h01, 16'h0011, 8'h01);
        pop_chk("seq1", 1'b0, 8'h02, 16'h0022, 8'h02);
        pop_chk("seq2", 1'b0, 8'h03, 16'h0033, 8'h03);
        chk("seq.empty", 32'(empty), 32'd1);

        // Simultaneous register and memory writes: register entry first, shared PC.
        push(1, 1, 4'h5, 8'h40, 16'hAAAA, 16'h5555, 8'h12);
        chk("dual.count", 32'(count), 32'd2);
        pop_chk("dual0", 1'b0, 8'h05, 16'hAAAA, 8'h12);
        pop_chk("dual1", 1'b1, 8'h40, 16'h5555, 8'h12);

        // One free slot, dual event, no pop: memory entry lost, overflow set.
        for (int i = 1; i <= 7; i++) push(1, 0, 4'(i), 8'h00, 16'(i * 257), 16'h0, 8'h20);
        chk("ovf.pre", 32'(count), 32'd7);
        push(1, 1, 4'h8, 8'h48, 16'h0808, 16'h4848, 8'h21);
        chk("ovf.count", 32'(count), 32'd8);
        chk("ovf.full", 32'(full), 32'd1);
        chk("ovf.flag", 32'(overflow), 32'd1);
        push(1, 0, 4'h9, 8'h00, 16'h0909, 16'h0, 8'h22);
        chk("full.count", 32'(count), 32'd8);
        chk("full.head", 32'(trace_data), 32'h0101);

        // Re-arm during capture discards contents and clears overflow.
        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm.state", 32'(state), 32'd1);
        chk("rearm.count", 32'(count), 32'd0);
        chk("rearm.ovf", 32'(overflow), 32'd0);
        chk("rearm.data", 32'(trace_data), 32'd0);

        // One free slot plus a same-cycle pop: both entries fit.
        for (int i = 1; i <= 7; i++) push(1, 0, 4'(i), 8'h00, 16'(i * 257), 16'h0, 8'h20);
        trace_ready = 1'b1;
        push(1, 1, 4'h8, 8'h48, 16'h0808, 16'h4848, 8'h21);
        trace_ready = 1'b0;
        chk("pp.count", 32'(count), 32'd8);
        chk("pp.ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 7; i++) pop_chk("pp.drain", 1'b0, 8'(i), 16'(i * 257), 8'h20);
        pop_chk("pp.reg", 1'b0, 8'h08, 16'h0808, 8'h21);
        pop_chk("pp.mem", 1'b1, 8'h48, 16'h4848, 8'h21);
        chk("pp.empty", 32'(empty), 32'd1);

        // Stop: the stop-cycle event is kept, later events and arm are ignored.
        push(1, 0, 4'h6, 8'h00, 16'h0606, 16'h0, 8'h30);
        instr_stop = 1'b1;
        push(1, 0, 4'h7, 8'h00, 16'h0707, 16'h0, 8'h31);
        instr_stop = 1'b0;
        chk("stop.state", 32'(state), 32'd2);
        chk("stop.count", 32'(count), 32'd2);
        push(1, 1, 4'hA, 8'h50, 16'h1111, 16'h2222, 8'h32);
        chk("frozen.count", 32'(count), 32'd2);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("frozen.arm", 32'(state), 32'd2);
        pop_chk("frz0", 1'b0, 8'h06, 16'h0606, 8'h30);
        pop_chk("frz1", 1'b0, 8'h07, 16'h0707, 8'h31);
        chk("drain.empty", 32'(empty), 32'd1);
        tick();
        chk("drain.idle", 32'(state), 32'd0);
        push(1, 0, 4'h1, 8'h00, 16'hFFFF, 16'h0, 8'h33);
        chk("idle.count", 32'(count), 32'd0);

`ifdef WB_TRACE_TIMESTAMP_EN
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (6) tick();
        push(1, 0, 4'h2, 8'h00, 16'h0707, 16'h0, 8'h40);
        chk("ts.value", 32'(trace_ts), 32'd7);
`endif

        // Asynchronous reset between edges with five entries held.
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 1; i <= 5; i++) push(1, 0, 4'(i), 8'h00, 16'(i * 16), 16'h0, 8'(i));
        chk("mid.count", 32'(count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("arst");
        tick();
        reset = 1'b0;
        tick();
        chk("post.state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
